// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle controller for the R-type shift instructions
// (SLL/SRL/SRA/SLLV/SRLV/SRAV). It accepts one decoded instruction through a
// valid/ready handshake, walks a narrow shifter STEP positions per cycle, and
// returns the shifted value through a second valid/ready handshake.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       inst31_26,
  input  logic [5:0]       inst5_0,
  input  logic [4:0]       inst10_6,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2
  } op_t;

  localparam logic [4:0] STEP_K = 5'(STEP);

  state_t state;
  op_t    op;
  logic [4:0] rem;

  op_t        dec_op;
  logic [4:0] dec_n;
  logic       dec_illegal;

  logic [4:0]              k;
  logic [WIDTH-1:0]        shifted;
  logic signed [WIDTH-1:0] result_s;

  // Only the low five bits of rs_data form a shift amount; the rest is dropped.
  logic unused_rs_high;
  assign unused_rs_high = ^rs_data[WIDTH-1:5];

  // Decode the opcode/funct pair into a shift kind and amount, flagging anything else.
  always_comb begin
    dec_illegal = 1'b0;
    dec_op      = OP_SLL;
    dec_n       = inst10_6;
    if (inst31_26 != 6'b000000) begin
      dec_illegal = 1'b1;
    end else begin
      case (inst5_0)
        6'b000000: begin dec_op = OP_SLL; dec_n = inst10_6;     end
        6'b000010: begin dec_op = OP_SRL; dec_n = inst10_6;     end
        6'b000011: begin dec_op = OP_SRA; dec_n = inst10_6;     end
        6'b000100: begin dec_op = OP_SLL; dec_n = rs_data[4:0]; end
        6'b000110: begin dec_op = OP_SRL; dec_n = rs_data[4:0]; end
        6'b000111: begin dec_op = OP_SRA; dec_n = rs_data[4:0]; end
        default:   dec_illegal = 1'b1;
      endcase
    end
  end

  // One partial shift: move by the smaller of STEP and what is still left to do.
  always_comb begin
    k        = (rem > STEP_K) ? STEP_K : rem;
    result_s = result;
    shifted  = result;
    case (op)
      OP_SLL:  shifted = result << k;
      OP_SRL:  shifted = result >> k;
      default: shifted = result_s >>> k;
    endcase
  end

  // Control FSM: accept in IDLE, iterate in SHIFT, present and hold in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op        <= OP_SLL;
      rem       <= 5'd0;
      result    <= '0;
      illegal   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op       <= dec_op;
            rem      <= dec_n;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (dec_illegal) begin
              result    <= '0;
              illegal   <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (dec_n == 5'd0) begin
              result    <= rt_data;
              illegal   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              result  <= rt_data;
              illegal <= 1'b0;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          result <= shifted;
          rem    <= rem - k;
          if (rem == k) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: two copies (STEP=1 and STEP=4) share every input,
// so each directed vector checks the same result at two different latencies.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [5:0]  inst31_26;
  logic [5:0]  inst5_0;
  logic [4:0]  inst10_6;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, illegal_a, busy_a;
  logic [31:0] result_a;
  logic        in_ready_b, out_valid_b, illegal_b, busy_b;
  logic [31:0] result_b;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_result;
    logic        exp_illegal;
    int          lat_a;
    int          lat_b;
  } vec_t;

  vec_t vecs[15];

  shift_sequencer #(.WIDTH(32), .STEP(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .inst31_26(inst31_26), .inst5_0(inst5_0), .inst10_6(inst10_6),
    .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid_a),
    .out_ready(out_ready), .result(result_a), .illegal(illegal_a), .busy(busy_a)
  );

  shift_sequencer #(.WIDTH(32), .STEP(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .inst31_26(inst31_26), .inst5_0(inst5_0), .inst10_6(inst10_6),
    .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid_b),
    .out_ready(out_ready), .result(result_b), .illegal(illegal_b), .busy(busy_b)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Safety net so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
  endtask

  // Drive one instruction, count edges to out_valid on both copies, check, then release.
  task automatic applyStimulus(input vec_t v, input int idx);
    int edges;
    int got_a;
    int got_b;
    checkOutput($sformatf("v%0d in_ready_a", idx), {31'd0, in_ready_a}, 32'd1);
    checkOutput($sformatf("v%0d in_ready_b", idx), {31'd0, in_ready_b}, 32'd1);
    inst31_26 = v.opcode;
    inst5_0   = v.funct;
    inst10_6  = v.shamt;
    rs_data   = v.rs;
    rt_data   = v.rt;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    inst5_0   = ~v.funct;
    inst10_6  = ~v.shamt;
    rs_data   = ~v.rs;
    rt_data   = ~v.rt;
    edges = 1;
    got_a = 0;
    got_b = 0;
    while ((got_a == 0 || got_b == 0) && edges <= 64) begin
      if (out_valid_a && got_a == 0) got_a = edges;
      if (out_valid_b && got_b == 0) got_b = edges;
      if (got_a == 0 || got_b == 0) begin
        @(posedge clk); #1;
        edges++;
      end
    end
    checkOutput($sformatf("v%0d latency_a", idx), got_a, v.lat_a);
    checkOutput($sformatf("v%0d latency_b", idx), got_b, v.lat_b);
    checkOutput($sformatf("v%0d result_a", idx), result_a, v.exp_result);
    checkOutput($sformatf("v%0d result_b", idx), result_b, v.exp_result);
    checkOutput($sformatf("v%0d illegal_a", idx), {31'd0, illegal_a}, {31'd0, v.exp_illegal});
    checkOutput($sformatf("v%0d illegal_b", idx), {31'd0, illegal_b}, {31'd0, v.exp_illegal});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput($sformatf("v%0d out_valid_a released", idx), {31'd0, out_valid_a}, 32'd0);
    checkOutput($sformatf("v%0d out_valid_b released", idx), {31'd0, out_valid_b}, 32'd0);
    checkOutput($sformatf("v%0d busy_a released", idx), {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    vec_t rv;
    int stray;
    int waited;

    //             opcode     funct      shamt  rs            rt            result        ill   a   b
    vecs[0]  = '{6'b000000, 6'b000000, 5'd4,  32'h0,        32'h00000001, 32'h00000010, 1'b0, 5,  2};
    vecs[1]  = '{6'b000000, 6'b000111, 5'd0,  32'h00000021, 32'h80000000, 32'hC0000000, 1'b0, 2,  2};
    vecs[2]  = '{6'b000000, 6'b000111, 5'd0,  32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32, 9};
    vecs[3]  = '{6'b000000, 6'b000010, 5'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1,  1};
    vecs[4]  = '{6'b100011, 6'b000000, 5'd4,  32'h0,        32'h12345678, 32'h00000000, 1'b1, 1,  1};
    vecs[5]  = '{6'b000000, 6'b100000, 5'd4,  32'h0,        32'h12345678, 32'h00000000, 1'b1, 1,  1};
    vecs[6]  = '{6'b000000, 6'b000010, 5'd7,  32'h0,        32'h80000000, 32'h01000000, 1'b0, 8,  3};
    vecs[7]  = '{6'b000000, 6'b000011, 5'd7,  32'h0,        32'h80000000, 32'hFF000000, 1'b0, 8,  3};
    vecs[8]  = '{6'b000000, 6'b000100, 5'd0,  32'hFFFFFFE3, 32'h0000000F, 32'h00000078, 1'b0, 4,  2};
    vecs[9]  = '{6'b000000, 6'b000110, 5'd0,  32'h00000010, 32'hABCD1234, 32'h0000ABCD, 1'b0, 17, 5};
    vecs[10] = '{6'b000000, 6'b000011, 5'd5,  32'h0,        32'h7FFFFFFF, 32'h03FFFFFF, 1'b0, 6,  3};
    vecs[11] = '{6'b000000, 6'b000000, 5'd31, 32'h0,        32'h00000003, 32'h80000000, 1'b0, 32, 9};
    vecs[12] = '{6'b000000, 6'b000111, 5'd0,  32'h00000006, 32'hF0000000, 32'hFFC00000, 1'b0, 7,  3};
    vecs[13] = '{6'b000000, 6'b000110, 5'd9,  32'hFFFFFFE0, 32'h12345678, 32'h12345678, 1'b0, 1,  1};
    vecs[14] = '{6'b000000, 6'b000001, 5'd3,  32'h0,        32'h00000001, 32'h00000000, 1'b1, 1,  1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inst31_26 = 6'd0;
    inst5_0   = 6'd0;
    inst10_6  = 5'd0;
    rs_data   = 32'd0;
    rt_data   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready_a", {31'd0, in_ready_a}, 32'd1);
    checkOutput("reset out_valid_a", {31'd0, out_valid_a}, 32'd0);
    checkOutput("reset result_a", result_a, 32'd0);
    checkOutput("reset illegal_a", {31'd0, illegal_a}, 32'd0);
    checkOutput("reset busy_a", {31'd0, busy_a}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

    $display("[TB] hold in DONE with stray in_valid pulses");
    inst31_26 = 6'b000000;
    inst5_0   = 6'b000000;
    inst10_6  = 5'd3;
    rt_data   = 32'h00000001;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    checkOutput("hold busy_a in SHIFT", {31'd0, busy_a}, 32'd1);
    checkOutput("hold in_ready_a in SHIFT", {31'd0, in_ready_a}, 32'd0);
    inst5_0  = 6'b000010;
    rt_data  = 32'hFFFFFFFF;
    waited = 0;
    while (!(out_valid_a && out_valid_b) && waited < 40) begin
      in_valid = ~in_valid;
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("hold reached DONE", {31'd0, out_valid_a & out_valid_b}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 2) == 0;
      @(posedge clk); #1;
      checkOutput($sformatf("hold c%0d out_valid_a", c), {31'd0, out_valid_a}, 32'd1);
      checkOutput($sformatf("hold c%0d result_a", c), result_a, 32'h00000008);
      checkOutput($sformatf("hold c%0d result_b", c), result_b, 32'h00000008);
      checkOutput($sformatf("hold c%0d in_ready_b", c), {31'd0, in_ready_b}, 32'd0);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("release out_valid_a", {31'd0, out_valid_a}, 32'd0);
    checkOutput("release no accept busy_a", {31'd0, busy_a}, 32'd0);
    checkOutput("release in_ready_a", {31'd0, in_ready_a}, 32'd1);
    checkOutput("release in_ready_b", {31'd0, in_ready_b}, 32'd1);
    @(posedge clk); #1;

    $display("[TB] reset during SHIFT and DONE");
    inst31_26 = 6'b000000;
    inst5_0   = 6'b000000;
    inst10_6  = 5'd20;
    rt_data   = 32'h00000001;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("pre-reset busy_a", {31'd0, busy_a}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort in_ready_a", {31'd0, in_ready_a}, 32'd1);
    checkOutput("abort busy_a", {31'd0, busy_a}, 32'd0);
    checkOutput("abort result_a", result_a, 32'd0);
    checkOutput("abort out_valid_b", {31'd0, out_valid_b}, 32'd0);
    checkOutput("abort result_b", result_b, 32'd0);
    checkOutput("abort busy_b", {31'd0, busy_b}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (out_valid_a || out_valid_b || busy_a || busy_b) stray++;
    end
    checkOutput("abort no late out_valid", stray, 32'd0);
    rv = '{6'b000000, 6'b000000, 5'd2, 32'h0, 32'h00000003, 32'h0000000C, 1'b0, 3, 2};
    applyStimulus(rv, 99);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
